// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: pipeline freeze/flush/bubble sequencing and data-memory handshake FSM
//
// Ports:
//   clk, rst              clock (rising edge), asynchronous active-low reset
//   id_src1/id_src2       source registers of the ID-stage instruction
//   id_uses_src1/two_src  qualify which sources the ID instruction actually reads
//   exe_wb_en/exe_dest    EXE-stage writeback enable and destination
//   mem_wb_en/mem_dest    MEM-stage writeback enable and destination
//   branch_taken          EXE resolved a taken branch this cycle
//   mem_r_en/mem_w_en     MEM-stage instruction is a load/store
//   sram_ready            memory completed the current access
//   freeze                hold PC, IF and ID registers
//   flush                 clear IF and ID registers
//   id_bubble             load a NOP into ID->EXE
//   mem_stall             hold EXE->MEM and MEM->WB
//   sram_req              memory access request (registered, high in ACCESS)
//   mem_timeout           sticky access-timeout flag, cleared only by reset
//   stall_cycles          saturating count of cycles with freeze high
module pipeline_hazard_ctrl #(
    parameter int REG_ADDR_LEN = 4,
    parameter int TIMEOUT      = 63,
    parameter int CNT_LEN      = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [REG_ADDR_LEN-1:0] id_src1,
    input  logic [REG_ADDR_LEN-1:0] id_src2,
    input  logic                    id_two_src,
    input  logic                    id_uses_src1,
    input  logic                    exe_wb_en,
    input  logic                    mem_wb_en,
    input  logic [REG_ADDR_LEN-1:0] exe_dest,
    input  logic [REG_ADDR_LEN-1:0] mem_dest,
    input  logic                    branch_taken,
    input  logic                    mem_r_en,
    input  logic                    mem_w_en,
    input  logic                    sram_ready,
    output logic                    freeze,
    output logic                    flush,
    output logic                    id_bubble,
    output logic                    mem_stall,
    output logic                    sram_req,
    output logic                    mem_timeout,
    output logic [CNT_LEN-1:0]      stall_cycles
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_e;

    state_e              state_q, state_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                timeout_q, timeout_d;
    logic [CNT_LEN-1:0]  stall_q, stall_d;
    logic                mem_req, exe_hit, mem_hit, hz;

    assign mem_req = mem_r_en | mem_w_en;

    // A producer only matters for sources the ID instruction really reads.
    assign exe_hit = exe_wb_en & ((id_uses_src1 & (exe_dest == id_src1)) |
                                  (id_two_src   & (exe_dest == id_src2)));
    assign mem_hit = mem_wb_en & ((id_uses_src1 & (mem_dest == id_src1)) |
                                  (id_two_src   & (mem_dest == id_src2)));
    assign hz      = exe_hit | mem_hit;

    // The ready cycle itself releases the stall so the pipeline advances on that edge.
    assign mem_stall = ((state_q == IDLE) & mem_req) | ((state_q == ACCESS) & ~sram_ready);
    // A taken branch is held in EXE by mem_stall and flushes in the first unstalled cycle.
    assign flush     = branch_taken & ~mem_stall;
    assign freeze    = mem_stall | (hz & ~flush);
    assign id_bubble = hz & ~mem_stall & ~flush;

    assign sram_req     = (state_q == ACCESS);
    assign mem_timeout  = timeout_q;
    assign stall_cycles = stall_q;

    always_comb begin
        state_d   = state_q;
        wait_d    = wait_q;
        timeout_d = timeout_q;
        case (state_q)
            IDLE: begin
                if (mem_req) begin
                    state_d = ACCESS;
                    wait_d  = '0;
                end
            end
            ACCESS: begin
                wait_d = wait_q + 1'b1;
                // wait_q counts completed ACCESS cycles, so this is the TIMEOUT-th one.
                if (sram_ready) begin
                    state_d = DONE;
                end else if (wait_q == WAIT_W'(TIMEOUT - 1)) begin
                    state_d   = DONE;
                    timeout_d = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        stall_d = (freeze && stall_q != '1) ? stall_q + 1'b1 : stall_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            wait_q    <= '0;
            timeout_q <= 1'b0;
            stall_q   <= '0;
        end else begin
            state_q   <= state_d;
            wait_q    <= wait_d;
            timeout_q <= timeout_d;
            stall_q   <= stall_d;
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: table vectors, corner sequences and random run against a reference model
module tb_pipeline_hazard_ctrl;

    localparam int RA = 4;
    localparam int TO = 5;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [RA-1:0] id_src1, id_src2, exe_dest, mem_dest;
    logic          id_two_src, id_uses_src1, exe_wb_en, mem_wb_en;
    logic          branch_taken, mem_r_en, mem_w_en, sram_ready;
    logic          freeze, flush, id_bubble, mem_stall, sram_req, mem_timeout;
    logic [CW-1:0] stall_cycles;

    pipeline_hazard_ctrl #(.REG_ADDR_LEN(RA), .TIMEOUT(TO), .CNT_LEN(CW)) dut (
        .clk(clk), .rst(rst),
        .id_src1(id_src1), .id_src2(id_src2),
        .id_two_src(id_two_src), .id_uses_src1(id_uses_src1),
        .exe_wb_en(exe_wb_en), .mem_wb_en(mem_wb_en),
        .exe_dest(exe_dest), .mem_dest(mem_dest),
        .branch_taken(branch_taken),
        .mem_r_en(mem_r_en), .mem_w_en(mem_w_en), .sram_ready(sram_ready),
        .freeze(freeze), .flush(flush), .id_bubble(id_bubble),
        .mem_stall(mem_stall), .sram_req(sram_req),
        .mem_timeout(mem_timeout), .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: an access is "outstanding" for some number of waited cycles,
    // followed by one cool-down cycle in which a new request is not accepted.
    bit m_busy, m_cool, m_tout;
    int m_waited, m_stalls;
    bit e_stall, e_flush, e_freeze, e_bub;

    function automatic bit reads(bit en, int d);
        return en && ((id_uses_src1 && d == int'(id_src1)) || (id_two_src && d == int'(id_src2)));
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vecs++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_cool = 0; m_tout = 0; m_waited = 0; m_stalls = 0;
    endtask

    task automatic model_eval();
        bit req, hz;
        req      = mem_r_en || mem_w_en;
        hz       = reads(exe_wb_en, int'(exe_dest)) || reads(mem_wb_en, int'(mem_dest));
        e_stall  = (!m_busy && !m_cool && req) || (m_busy && !sram_ready);
        e_flush  = branch_taken && !e_stall;
        e_freeze = e_stall || (hz && !e_flush);
        e_bub    = hz && !e_stall && !e_flush;
    endtask

    task automatic model_edge();
        if (e_freeze && m_stalls < (1 << CW) - 1) m_stalls++;
        if (m_busy) begin
            m_waited++;
            if (sram_ready) begin
                m_busy = 0; m_cool = 1;
            end else if (m_waited == TO) begin
                m_busy = 0; m_cool = 1; m_tout = 1;
            end
        end else if (m_cool) begin
            m_cool = 0;
        end else if (mem_r_en || mem_w_en) begin
            m_busy = 1; m_waited = 0;
        end
    endtask

    task automatic check_all();
        model_eval();
        chk("freeze", freeze, e_freeze);
        chk("flush", flush, e_flush);
        chk("id_bubble", id_bubble, e_bub);
        chk("mem_stall", mem_stall, e_stall);
        chk("sram_req", sram_req, m_busy);
        chk("mem_timeout", mem_timeout, m_tout);
        chk("stall_cycles", stall_cycles, m_stalls);
    endtask

    // Inputs are driven just after a rising edge; outputs are checked on the falling edge.
    task automatic cyc();
        @(negedge clk);
        check_all();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 0; id_src2 = 0; exe_dest = 0; mem_dest = 0;
        id_two_src = 0; id_uses_src1 = 0; exe_wb_en = 0; mem_wb_en = 0;
        branch_taken = 0; mem_r_en = 0; mem_w_en = 0; sram_ready = 0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst = 0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1;
    endtask

    typedef struct {
        logic          ewb;
        logic [RA-1:0] ed;
        logic          mwb;
        logic [RA-1:0] md;
        logic [RA-1:0] s1, s2;
        logic          u1, two, br;
        logic          fz, fl, bb;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int ns, nr, nf;
        clear_inputs();
        rst = 0;
        model_reset();
        #12;
        rst = 1;
        @(posedge clk);
        #1;
        cyc();
        chk("reset_stall_cycles", stall_cycles, 0);
        chk("reset_timeout", mem_timeout, 0);
        chk("reset_sram_req", sram_req, 0);

        //            ewb ed mwb md s1 s2 u1 two br   fz fl bb
        tbl[0] = '{1, 3, 0, 0, 3, 0, 1, 0, 0,  1, 0, 1};
        tbl[1] = '{1, 3, 0, 0, 0, 3, 1, 0, 0,  0, 0, 0};
        tbl[2] = '{1, 3, 0, 0, 0, 3, 1, 1, 0,  1, 0, 1};
        tbl[3] = '{1, 3, 0, 0, 3, 0, 0, 0, 0,  0, 0, 0};
        tbl[4] = '{0, 0, 1, 7, 1, 7, 1, 1, 0,  1, 0, 1};
        tbl[5] = '{1, 3, 0, 0, 3, 0, 1, 0, 1,  0, 1, 0};
        tbl[6] = '{0, 0, 0, 0, 2, 5, 1, 1, 1,  0, 1, 0};
        tbl[7] = '{0, 3, 0, 3, 3, 3, 1, 1, 0,  0, 0, 0};
        for (int i = 0; i < 8; i++) begin
            exe_wb_en = tbl[i].ewb; exe_dest = tbl[i].ed;
            mem_wb_en = tbl[i].mwb; mem_dest = tbl[i].md;
            id_src1 = tbl[i].s1; id_src2 = tbl[i].s2;
            id_uses_src1 = tbl[i].u1; id_two_src = tbl[i].two;
            branch_taken = tbl[i].br;
            #1;
            chk($sformatf("tbl%0d_freeze", i), freeze, tbl[i].fz);
            chk($sformatf("tbl%0d_flush", i), flush, tbl[i].fl);
            chk($sformatf("tbl%0d_bubble", i), id_bubble, tbl[i].bb);
            cyc();
        end

        // Load: IDLE-detect, three waiting ACCESS cycles, ready on the fourth, then DONE.
        do_reset();
        ns = 0; nr = 0;
        for (int i = 0; i < 7; i++) begin
            mem_r_en = (i <= 5);
            sram_ready = (i == 4);
            #1;
            ns += int'(mem_stall);
            nr += int'(sram_req);
            if (i == 5) begin
                chk("done_no_retrigger", mem_stall, 0);
                chk("done_req_low", sram_req, 0);
            end
            cyc();
        end
        chk("load_stall_len", ns, 4);
        chk("load_req_len", nr, 4);
        chk("load_stall_cycles", stall_cycles, 4);

        // Taken branch held through a memory stall.
        do_reset();
        nf = 0;
        branch_taken = 1;
        for (int i = 0; i < 5; i++) begin
            mem_w_en = 1;
            sram_ready = (i == 4);
            #1;
            if (mem_stall) nf += int'(flush);
            if (i == 4) chk("branch_after_stall", flush, 1);
            cyc();
        end
        chk("branch_during_stall", nf, 0);
        clear_inputs();
        cyc();

        // Timeout: ready never comes.
        do_reset();
        mem_r_en = 1;
        for (int i = 0; i < 6; i++) begin
            #1;
            if (i == 5) begin
                chk("pre_timeout_flag", mem_timeout, 0);
                chk("pre_timeout_req", sram_req, 1);
            end
            cyc();
        end
        mem_r_en = 0;
        #1;
        chk("timeout_flag", mem_timeout, 1);
        chk("timeout_done_req", sram_req, 0);
        cyc();
        mem_w_en = 1;
        cyc();
        sram_ready = 1;
        cyc();
        mem_w_en = 0; sram_ready = 0;
        cyc();
        cyc();
        chk("timeout_sticky", mem_timeout, 1);

        // Reset in the middle of an access.
        mem_r_en = 1;
        cyc();
        cyc();
        chk("mid_access_req", sram_req, 1);
        rst = 0;
        #1;
        chk("async_reset_req", sram_req, 0);
        chk("async_reset_timeout", mem_timeout, 0);
        chk("async_reset_stalls", stall_cycles, 0);
        model_reset();
        mem_r_en = 0;
        @(posedge clk);
        #1;
        rst = 1;
        cyc();

        // Random run.
        for (int n = 0; n < 600; n++) begin
            id_src1 = RA'($urandom_range(0, 3));
            id_src2 = RA'($urandom_range(0, 3));
            exe_dest = RA'($urandom_range(0, 3));
            mem_dest = RA'($urandom_range(0, 3));
            id_uses_src1 = $urandom_range(0, 3) != 0;
            id_two_src = $urandom_range(0, 1) != 0;
            exe_wb_en = $urandom_range(0, 2) == 0;
            mem_wb_en = $urandom_range(0, 2) == 0;
            branch_taken = $urandom_range(0, 4) == 0;
            mem_r_en = $urandom_range(0, 4) == 0;
            mem_w_en = $urandom_range(0, 5) == 0;
            sram_ready = $urandom_range(0, 3) == 0;
            cyc();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
